bcd_step_counter: RTL and testbench

BCD_STEP_COUNTER -- requirements
Module: bcd_step_counter

---
 rtl/bcd_step_counter.sv | 89 ++++++++
 tb/tb_bcd_step_counter.sv | 182 ++++++++++++++++++
 2 files changed

// File: rtl/bcd_step_counter.sv
// bcd_step_counter: two-digit BCD up/down step counter with edge-detected steps, holdoff, wrap/clamp
// Ports: clk_200H clock; rst_n async active-low reset; en enables counting;
//        step_pulse step request (rising edge counts); dir 1=up 0=down; clr sync clear of digits;
//        bcd_tens/bcd_ones count digits; wrap 1-cycle limit event flag; busy high during holdoff.
module bcd_step_counter #(
  parameter int unsigned HOLDOFF  = 20,
  parameter bit          SATURATE = 1'b0
) (
  input  logic       clk_200H,
  input  logic       rst_n,
  input  logic       en,
  input  logic       step_pulse,
  input  logic       dir,
  input  logic       clr,
  output logic [3:0] bcd_tens,
  output logic [3:0] bcd_ones,
  output logic       wrap,
  output logic       busy
);
  typedef enum logic [1:0] {S_IDLE, S_ARMED, S_HOLDOFF} state_t;
  state_t     r_state, w_next;
  logic [7:0] r_hold, w_hold_next;
  logic       r_prev, r_wrap, r_busy;
  logic [3:0] r_tens, r_ones;
  logic       w_accept, w_lim;
  logic [3:0] w_tens_up, w_ones_up, w_tens_dn, w_ones_dn;
  assign w_accept  = (r_state == S_ARMED) && en && step_pulse && !r_prev;
  assign w_lim     = dir ? (r_tens == 4'd9 && r_ones == 4'd9) : (r_tens == 4'd0 && r_ones == 4'd0);
  assign w_ones_up = (r_ones == 4'd9) ? 4'd0 : r_ones + 4'd1;
  assign w_tens_up = (r_ones == 4'd9) ? ((r_tens == 4'd9) ? 4'd0 : r_tens + 4'd1) : r_tens;
  assign w_ones_dn = (r_ones == 4'd0) ? 4'd9 : r_ones - 4'd1;
  assign w_tens_dn = (r_ones == 4'd0) ? ((r_tens == 4'd0) ? 4'd9 : r_tens - 4'd1) : r_tens;
  always_comb begin
    w_next      = r_state;
    w_hold_next = r_hold;
    if (!en) begin
      w_next      = S_IDLE;
      w_hold_next = 8'd0;
    end else begin
      unique case (r_state)
        S_IDLE: w_next = S_ARMED;
        S_ARMED: if (w_accept && HOLDOFF != 0) begin
          w_next      = S_HOLDOFF;
          w_hold_next = 8'(HOLDOFF);
        end
        S_HOLDOFF: begin
          w_hold_next = r_hold - 8'd1;
          if (r_hold <= 8'd1) begin
            w_next      = S_ARMED;
            w_hold_next = 8'd0;
          end
        end
        default: w_next = S_IDLE;
      endcase
    end
  end
  always_ff @(posedge clk_200H or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
      r_hold  <= 8'd0;
      r_prev  <= 1'b1;
      r_busy  <= 1'b0;
      r_wrap  <= 1'b0;
      r_tens  <= 4'd0;
      r_ones  <= 4'd0;
    end else begin
      r_state <= w_next;
      r_hold  <= w_hold_next;
      r_prev  <= step_pulse;
      r_busy  <= (w_next == S_HOLDOFF);
      r_wrap  <= 1'b0;
      if (clr) begin
        r_tens <= 4'd0;
        r_ones <= 4'd0;
      end else if (w_accept) begin
        r_wrap <= w_lim;
        // at a limit with clamping the digits stay put; only the flag pulses
        if (!(w_lim && SATURATE)) begin
          r_tens <= dir ? w_tens_up : w_tens_dn;
          r_ones <= dir ? w_ones_up : w_ones_dn;
        end
      end
    end
  end
  assign bcd_tens = r_tens;
  assign bcd_ones = r_ones;
  assign wrap     = r_wrap;
  assign busy     = r_busy;
endmodule

// File: tb/tb_bcd_step_counter.sv
// tb_bcd_step_counter: checks three counter configurations against an integer reference model
module tb_bcd_step_counter;
  logic clk = 0, rst_n = 1, en = 0, step = 0, dir = 0, clr = 0;
  logic [3:0] tens[3], ones[3];
  logic wr[3], bsy[3];
  int checks = 0, errors = 0;
  int ho[3]  = '{20, 20, 0};
  bit sat[3] = '{1'b0, 1'b1, 1'b0};
  int m_cnt[3], m_rem[3];
  bit m_on[3], m_wrap[3], m_prev;
  typedef struct {bit stp; bit d; bit c; int e0; int e1; bit w0; bit w1;} vec_t;
  vec_t tbl[23];
  always #5 clk = ~clk;
  bcd_step_counter #(.HOLDOFF(20), .SATURATE(1'b0)) u0 (.clk_200H(clk), .rst_n(rst_n), .en(en),
    .step_pulse(step), .dir(dir), .clr(clr), .bcd_tens(tens[0]), .bcd_ones(ones[0]), .wrap(wr[0]), .busy(bsy[0]));
  bcd_step_counter #(.HOLDOFF(20), .SATURATE(1'b1)) u1 (.clk_200H(clk), .rst_n(rst_n), .en(en),
    .step_pulse(step), .dir(dir), .clr(clr), .bcd_tens(tens[1]), .bcd_ones(ones[1]), .wrap(wr[1]), .busy(bsy[1]));
  bcd_step_counter #(.HOLDOFF(0), .SATURATE(1'b0)) u2 (.clk_200H(clk), .rst_n(rst_n), .en(en),
    .step_pulse(step), .dir(dir), .clr(clr), .bcd_tens(tens[2]), .bcd_ones(ones[2]), .wrap(wr[2]), .busy(bsy[2]));
  task automatic chk(string nm, int act, int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endtask
  function automatic int cnt_of(int i);
    return int'(tens[i]) * 10 + int'(ones[i]);
  endfunction
  task automatic compare_all();
    for (int i = 0; i < 3; i++) begin
      chk($sformatf("u%0d tens", i), int'(tens[i]), m_cnt[i] / 10);
      chk($sformatf("u%0d ones", i), int'(ones[i]), m_cnt[i] % 10);
      chk($sformatf("u%0d wrap", i), int'(wr[i]), int'(m_wrap[i]));
      chk($sformatf("u%0d busy", i), int'(bsy[i]), int'(m_rem[i] > 0));
    end
  endtask
  task automatic model_reset();
    for (int i = 0; i < 3; i++) begin
      m_cnt[i] = 0; m_rem[i] = 0; m_on[i] = 0; m_wrap[i] = 0;
    end
    m_prev = 1;
  endtask
  task automatic tick();
    int nc[3], nr[3];
    bit non[3], nw[3], acc;
    for (int i = 0; i < 3; i++) begin
      acc = en && m_on[i] && m_rem[i] == 0 && step && !m_prev;
      if (!en) begin non[i] = 0; nr[i] = 0; end
      else if (!m_on[i]) begin non[i] = 1; nr[i] = 0; end
      else if (m_rem[i] > 0) begin non[i] = 1; nr[i] = m_rem[i] - 1; end
      else begin non[i] = 1; nr[i] = acc ? ho[i] : 0; end
      nw[i] = 0;
      nc[i] = m_cnt[i];
      if (clr) nc[i] = 0;
      else if (acc) begin
        if (dir) begin
          nw[i] = (m_cnt[i] == 99);
          nc[i] = nw[i] ? (sat[i] ? 99 : 0) : m_cnt[i] + 1;
        end else begin
          nw[i] = (m_cnt[i] == 0);
          nc[i] = nw[i] ? (sat[i] ? 0 : 99) : m_cnt[i] - 1;
        end
      end
    end
    @(posedge clk);
    #1;
    for (int i = 0; i < 3; i++) begin
      m_cnt[i] = nc[i]; m_rem[i] = nr[i]; m_on[i] = non[i]; m_wrap[i] = nw[i];
    end
    m_prev = step;
    compare_all();
  endtask
  task automatic async_rst();
    #1 rst_n = 0;
    #1 model_reset();
    compare_all();
    #1 rst_n = 1;
  endtask
  task automatic step_up();
    step = 1; dir = 1;
    tick();
    step = 0;
    repeat (21) tick();
  endtask
  task automatic chk_cnts(string nm, int e0, int e1, int e2);
    chk({nm, " u0"}, cnt_of(0), e0);
    chk({nm, " u1"}, cnt_of(1), e1);
    chk({nm, " u2"}, cnt_of(2), e2);
  endtask
  initial begin
    for (int i = 0; i < 12; i++) tbl[i] = '{1, 1, 0, i + 1, i + 1, 0, 0};
    tbl[12] = '{1, 0, 0, 11, 11, 0, 0};
    tbl[13] = '{1, 0, 0, 10, 10, 0, 0};
    tbl[14] = '{1, 0, 0, 9, 9, 0, 0};
    tbl[15] = '{0, 0, 1, 0, 0, 0, 0};
    tbl[16] = '{1, 0, 0, 99, 0, 1, 1};
    tbl[17] = '{1, 0, 0, 98, 0, 0, 1};
    tbl[18] = '{1, 1, 0, 99, 1, 0, 0};
    tbl[19] = '{1, 1, 0, 0, 2, 1, 0};
    tbl[20] = '{1, 1, 0, 1, 3, 0, 0};
    tbl[21] = '{1, 1, 1, 0, 0, 0, 0};
    tbl[22] = '{1, 1, 0, 1, 1, 0, 0};
    #2 rst_n = 0;
    model_reset();
    repeat (3) @(posedge clk);
    #1 compare_all();
    #2 rst_n = 1;
    tick();
    en = 1; step = 1;
    tick();
    tick();
    chk_cnts("first edge no step", 0, 0, 0);
    step = 0;
    tick();
    for (int k = 0; k < 23; k++) begin
      step = tbl[k].stp; dir = tbl[k].d; clr = tbl[k].c;
      tick();
      chk_cnts($sformatf("vec%0d cnt", k), tbl[k].e0, tbl[k].e1, tbl[k].e0);
      chk($sformatf("vec%0d wrap u0", k), int'(wr[0]), int'(tbl[k].w0));
      chk($sformatf("vec%0d wrap u1", k), int'(wr[1]), int'(tbl[k].w1));
      step = 0; clr = 0;
      repeat (24) tick();
    end
    dir = 1;
    for (int k = 0; k < 3; k++) begin
      step = 1; tick();
      step = 0; repeat (4) tick();
    end
    repeat (21) tick();
    chk_cnts("pulses 5 apart", 2, 2, 4);
    step = 1;
    repeat (50) tick();
    step = 0;
    repeat (21) tick();
    chk_cnts("held 50", 3, 3, 5);
    clr = 1; tick(); clr = 0;
    repeat (99) step_up();
    chk_cnts("climb 99", 99, 99, 99);
    step = 1; tick(); step = 0;
    chk_cnts("past 99", 0, 99, 0);
    chk("past 99 wrap u1", int'(wr[1]), 1);
    repeat (21) tick();
    clr = 1; tick(); clr = 0;
    repeat (42) step_up();
    chk_cnts("at 42", 42, 42, 42);
    step = 1; clr = 1; tick(); step = 0; clr = 0;
    chk_cnts("clr with step", 0, 0, 0);
    chk("clr with step wrap", int'(wr[0]), 0);
    chk("clr with step busy", int'(bsy[0]), 1);
    repeat (21) tick();
    repeat (56) step_up();
    step = 1; tick(); step = 0;
    repeat (2) tick();
    chk_cnts("at 57", 57, 57, 57);
    chk("at 57 busy", int'(bsy[0]), 1);
    step = 1;
    async_rst();
    chk_cnts("mid reset", 0, 0, 0);
    chk("mid reset busy", int'(bsy[0]), 0);
    repeat (5) tick();
    chk_cnts("high at release", 0, 0, 0);
    step = 0;
    tick();
    step = 1; tick(); step = 0;
    repeat (5) tick();
    en = 0; tick();
    chk("en drop busy", int'(bsy[0]), 0);
    en = 1;
    repeat (3) tick();
    for (int k = 0; k < 5000; k++) begin
      en   = $urandom_range(0, 19) != 0;
      step = $urandom_range(0, 3) == 0;
      dir  = $urandom_range(0, 1) == 1;
      clr  = $urandom_range(0, 59) == 0;
      tick();
      if ($urandom_range(0, 299) == 0) async_rst();
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
